// File: rtl/seq_pkg.sv
// Shared definitions for the 0110-preamble serial frame transmitter and detector.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GAP
    } state_e;

    localparam int unsigned SYNC_LEN = 4;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b0110;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
module bit_tick_gen
    import seq_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_c,
    output logic tick_next_c
);

    localparam int unsigned DIV_W = cnt_width(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (clr_i || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // tick_next_c lets the owner register outputs that must line up with the wrap cycle.
    assign tick_c      = (div_q == DIV_LAST);
    assign tick_next_c = (div_d == DIV_LAST);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 0110 preamble, data MSB first, even parity, idle-high gap.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = cnt_width(max3(SYNC_LEN, DATA_W, GAP_BITS));

    state_e            state_q, state_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_d, in_ready_d, busy_d, done_d;
    logic              accept_c, tick_c, tick_next_c;
    logic [1:0]        pre_idx_c;

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept_c),
        .tick_c     (tick_c),
        .tick_next_c(tick_next_c)
    );

    // Next state and next line value; outputs are registered from the next-state view.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        accept_c   = 1'b0;
        tx_d       = 1'b1;
        pre_idx_c  = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = PRE;
                    bit_d    = '0;
                    shift_d  = in_data;
                    par_d    = ^in_data;
                end
            end
            PRE: begin
                if (tick_c) begin
                    if (bit_q == BIT_W'(SYNC_LEN - 1)) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = PAR;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (tick_c) begin
                    state_d = GAP;
                    bit_d   = '0;
                end
            end
            GAP: begin
                if (tick_c) begin
                    if (bit_q == BIT_W'(GAP_BITS - 1)) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
            end
        endcase

        pre_idx_c = 2'(SYNC_LEN - 1) - bit_d[1:0];
        unique case (state_d)
            PRE:     tx_d = SYNC_PATTERN[pre_idx_c];
            DATA:    tx_d = shift_d[DATA_W-1];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == GAP) && (bit_d == BIT_W'(GAP_BITS - 1)) && tick_next_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            tx       <= tx_d;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Payload and parity are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: frames, parity, divider, back-to-back, reset, 0110 loopback.
module tb_seq_frame_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_data1, in_data3;
    logic       in_valid1, in_valid3;
    logic       in_ready1, tx1, busy1, done1;
    logic       in_ready3, tx3, busy3, done3;

    int n_checks = 0;
    int n_errors = 0;

    seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .GAP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    seq_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .GAP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .tx(tx3), .busy(busy3), .done(done3)
    );

    // Reference 0110 detector on the line: Mealy output on the final preamble bit.
    logic [3:0] det_hist = 4'hF;
    logic       det_z;
    always @(posedge clk) det_hist <= {det_hist[2:0], tx1};
    assign det_z = ({det_hist[2:0], tx1} == SYNC_PATTERN);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Captures the 15 cycles after the handshake edge on the CLKS_PER_BIT=1 instance.
    task automatic run_frame1(input logic keep_valid, input logic [7:0] next_data,
                              output logic [14:0] bits, output int done_cyc,
                              output int n_done, output int bad_cyc);
        bits = '0; done_cyc = 0; n_done = 0; bad_cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                in_valid1 = keep_valid;
                in_data1  = next_data;
            end
            bits = {bits[13:0], tx1};
            if (done1) begin
                n_done++;
                done_cyc = c;
            end
            if (in_ready1 || !busy1) bad_cyc++;
        end
    endtask

    task automatic after_frame1(input string tag);
        @(posedge clk); #1;
        check({tag, "_ready16"}, 32'(in_ready1), 32'd1);
        check({tag, "_busy16"},  32'(busy1),     32'd0);
        check({tag, "_done16"},  32'(done1),     32'd0);
    endtask

    logic [14:0] bits, bits2, exp3, coll;
    logic [7:0]  part;
    logic        tx16;
    int          dc, nd, bad, np, np_idle, pc;

    initial begin
        rst = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0;
        in_data3 = '0; in_valid3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx",    32'(tx1),       32'd1);
        check("rst_ready", 32'(in_ready1), 32'd1);
        check("rst_busy",  32'(busy1),     32'd0);
        check("rst_done",  32'(done1),     32'd0);
        check("rst_tx3",   32'(tx3),       32'd1);
        check("rst_rdy3",  32'(in_ready3), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_tx", 32'(tx1), 32'd1);

        // Basic frame 0xA5: even number of ones, parity 0
        in_data1 = 8'hA5; in_valid1 = 1'b1;
        run_frame1(1'b0, 8'h00, bits, dc, nd, bad);
        check("a5_frame", 32'(bits), 32'(15'b0110_10100101_0_11));
        check("a5_done_cyc", 32'(dc), 32'd15);
        check("a5_done_cnt", 32'(nd), 32'd1);
        check("a5_ready_busy", 32'(bad), 32'd0);
        after_frame1("a5");

        // Single one: parity 1
        in_data1 = 8'h01; in_valid1 = 1'b1;
        run_frame1(1'b0, 8'h00, bits, dc, nd, bad);
        check("x01_frame", 32'(bits), 32'(15'b0110_00000001_1_11));
        check("x01_done_cyc", 32'(dc), 32'd15);
        after_frame1("x01");

        // Back-to-back with in_valid held; in_data changes mid-frame must not be sampled
        in_data1 = 8'h3C; in_valid1 = 1'b1;
        run_frame1(1'b1, 8'hC3, bits, dc, nd, bad);
        check("b2b1_frame", 32'(bits), 32'(15'b0110_00111100_0_11));
        check("b2b1_done_cyc", 32'(dc), 32'd15);
        @(posedge clk); #1;
        tx16 = tx1;
        check("b2b_ready16", 32'(in_ready1), 32'd1);
        run_frame1(1'b0, 8'h00, bits2, dc, nd, bad);
        check("b2b2_frame", 32'(bits2), 32'(15'b0110_11000011_0_11));
        check("b2b2_done_cyc", 32'(dc), 32'd15);
        check("b2b_line_gap", 32'({bits[1:0], tx16, bits2[14]}), 32'(4'b1110));
        after_frame1("b2b2");

        // Reset during DATA bit 3
        in_data1 = 8'hFF; in_valid1 = 1'b1;
        part = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_valid1 = 1'b0;
            part = {part[6:0], tx1};
        end
        check("rst_mid_prefix", 32'(part), 32'(8'b0110_1111));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_tx",    32'(tx1),       32'd1);
        check("rst_mid_ready", 32'(in_ready1), 32'd1);
        check("rst_mid_busy",  32'(busy1),     32'd0);
        nd = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1) nd++;
        end
        check("rst_mid_no_done", 32'(nd), 32'd0);
        in_data1 = 8'h5A; in_valid1 = 1'b1;
        run_frame1(1'b0, 8'h00, bits, dc, nd, bad);
        check("x5a_frame", 32'(bits), 32'(15'b0110_01011010_0_11));
        check("x5a_done_cyc", 32'(dc), 32'd15);
        after_frame1("x5a");

        // Divider: each bit held 3 cycles on the second instance
        exp3 = 15'b0110_11111111_0_11;
        coll = '0; bad = 0; dc = 0; nd = 0;
        in_data3 = 8'hFF; in_valid3 = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_valid3 = 1'b0;
            if (tx3 !== exp3[14 - (c - 1) / 3]) bad++;
            if ((c % 3) == 1) coll = {coll[13:0], tx3};
            if (done3) begin
                nd++;
                dc = c;
            end
        end
        check("div_frame", 32'(coll), 32'(exp3));
        check("div_hold", 32'(bad), 32'd0);
        check("div_done_cyc", 32'(dc), 32'd45);
        check("div_done_cnt", 32'(nd), 32'd1);
        @(posedge clk); #1;
        check("div_ready46", 32'(in_ready3), 32'd1);

        // Loopback into the 0110 detector with all-zero payload
        np_idle = 0; np = 0; pc = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (det_z) np_idle++;
        end
        in_data1 = 8'h00; in_valid1 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_valid1 = 1'b0;
            if (det_z) begin
                np++;
                pc = c;
            end
        end
        check("det_idle_pulses", 32'(np_idle), 32'd0);
        check("det_pulses", 32'(np), 32'd1);
        check("det_pulse_cyc", 32'(pc), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter that drives a one-bit line compatible with the team's `0110` sequence detector. It accepts a parallel word over a valid/ready handshake and emits the frame serially, MSB first: the sync preamble `0110`, the data word, an even-parity bit, then an idle gap. The line idles high, so a downstream detector sits in its reset state between frames.

## Interface
- `DATA_W`, default 8: payload width in bits; must be ≥1.
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held; must be ≥1.
- `GAP_BITS`, default 2: idle-high bit periods after parity; must be ≥1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_data` in DATA_W: word to transmit; sampled only on an accepted handshake.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a word this cycle.
- `tx` out 1: serial line; registered output.
- `busy` out 1: a frame, including its gap, is in progress.
- `done` out 1: one-cycle pulse marking the end of a frame's gap.

## Operation
- State machine states: IDLE, PRE, DATA, PAR, GAP.
- Reset values, set on any cycle where `rst`=1, including mid-frame:
  - state IDLE; `tx`=1, `in_ready`=1, `busy`=0, `done`=0.
  - bit counter and clock-divider counter cleared.
  - A frame interrupted by reset is abandoned with no `done`; the shift register contents are don't-care.
- IDLE:
  - `in_ready`=1 and `tx`=1.
  - When `in_valid`=1, the handshake is accepted on that edge: `in_data` is latched into the shift register, its even parity (XOR reduction) is latched, and the state moves to PRE.
- PRE: drives preamble bits 0,1,1,0 in order, then moves to DATA.
- DATA: drives shift-register bits MSB→LSB (DATA_W bits), then moves to PAR.
- PAR: drives the latched parity bit, chosen so the total count of ones in data plus parity is even. Then moves to GAP.
- GAP:
  - drives 1 for GAP_BITS bit periods.
  - `done`=1 on the final cycle of the last gap period; the next state is IDLE.
- Bit timing: a divider counts 0..CLKS_PER_BIT-1. The bit index advances only when the divider wraps.
- Counter widths:
  - bit counter is `$clog2` of max(4, DATA_W, GAP_BITS), minimum 1 bit.
  - divider is `$clog2(CLKS_PER_BIT)`, minimum 1 bit.
- `in_ready` = (state==IDLE), registered. It is 0 from the cycle after acceptance through the `done` cycle.
- `busy` = (state != IDLE).
- `in_valid` or `in_data` changes while not ready are ignored. `in_data` is never re-sampled mid-frame.

## Timing
- Latency: after handshake edge N, `tx` shows preamble bit 0 (value 0) from edge N+1.
- Frame length: (4 + DATA_W + 1 + GAP_BITS) × CLKS_PER_BIT cycles from edge N+1 to the `done` cycle inclusive.
- Back-to-back frames:
  - With `in_valid` held high, the next word is accepted on the first IDLE cycle after `done`.
  - Minimum line-high time between frames is GAP_BITS×CLKS_PER_BIT + 1 cycles.
- `done` and `in_ready` are never 1 on the same cycle.
- Reset mid-operation: `tx`=1 and `in_ready`=1 from the edge where `rst` is sampled high.

## Structure
- Shared package `seq_pkg`:
  - state encoding enum (IDLE, PRE, DATA, PAR, GAP).
  - preamble constant `SYNC_PATTERN` = 4'b0110 and `SYNC_LEN` = 4.
  - The detector reuses the same constant.
- One natural sub-module, `bit_tick_gen`: the CLKS_PER_BIT divider, producing a one-cycle `tick` on its wrap. It is cleared by `rst` and by handshake acceptance.
- The FSM and shift register stay in the top module.

## Test plan
- Basic frame:
  - Setup: DATA_W=8, CLKS_PER_BIT=1, GAP_BITS=2. Send `in_data`=8'hA5.
  - Required `tx` from N+1: 0,1,1,0, 1,0,1,0,0,1,0,1, 0 (parity), then 1,1.
  - `done` is high on the 15th cycle; `in_ready` returns high on the 16th cycle.
- Odd parity data: send 8'h01.
  - Parity bit = 1.
  - Frame data bits are 0000_0001 followed by 1.
- Divider:
  - Setup: CLKS_PER_BIT=3, data 8'hFF.
  - Each bit is held exactly 3 cycles; parity = 0.
  - Total 45 cycles to `done` inclusive.
- Back-to-back: `in_valid` held high with 8'h3C then 8'hC3.
  - Second acceptance occurs exactly 1 cycle after the first `done`.
  - The line is high for 3 cycles between frames (CLKS_PER_BIT=1, GAP_BITS=2).
- Reset mid-frame: assert `rst` for 1 cycle during DATA bit 3.
  - Next cycle: `tx`=1, `in_ready`=1, `busy`=0.
  - No `done` pulse.
  - A new frame with 8'h5A then transmits correctly.
- Detector loopback: connect `tx` to the existing `0110` detector and send 8'h00.
  - Exactly one detector `z` pulse, aligned to the preamble's final 0.
  - No pulses during the idle line.
